mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning request address width in bits (word address).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 The block SHALL have parameter DATA_DEPTH, default 256, meaning data region words (power of 2).
REQ-004 The block SHALL have parameter STACK_DEPTH, default 256, meaning stack region words (power of 2).
REQ-005 The block SHALL have parameter MMIO_REGS, default 8, meaning number of MMIO registers (power of 2).
REQ-006 The block SHALL have parameter WAIT_CYCLES, default 1, meaning extra access wait states (0..15).
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-010 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-011 The block SHALL have port req_we, input, 1 bit: 1 for write, 0 for read.
REQ-012 The block SHALL have port req_addr, input, ADDR_W bits: virtual word address.
REQ-013 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-014 The block SHALL have port resp_valid, output, 1 bit: response present.
REQ-015 The block SHALL have port resp_ready, input, 1 bit: consumer accepts the response.
REQ-016 The block SHALL have port resp_rdata, output, DATA_W bits: read data (0 for writes).
REQ-017 The block SHALL have port resp_fault, output, 1 bit: unmapped access.
REQ-018 The block SHALL have port mmio_q, output, MMIO_REGS*DATA_W bits: all MMIO registers, reg 0 in the LSBs.

Function
REQ-019 Region decode SHALL use req_addr[ADDR_W-1:ADDR_W-2]: 00 data, 01 stack, 10 MMIO, 11 unmapped.
REQ-020 The physical offset SHALL be the low log2(depth) bits of req_addr, so out-of-range offsets wrap modulo the region depth.
REQ-021 The FSM SHALL have exactly three states, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 A handshake (req_valid && req_ready) SHALL latch we, addr and wdata, then go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-023 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter, then go to RESP.
REQ-024 The access SHALL execute on the edge entering RESP: the write is committed, or read data is registered into resp_rdata.
REQ-025 Request-accept-to-resp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-026 resp_valid SHALL be 1 only in RESP; resp_rdata and resp_fault SHALL be held stable until resp_valid && resp_ready.
REQ-027 On resp_valid && resp_ready the FSM SHALL return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-028 Exactly one region SHALL be written per write; the other regions SHALL be unchanged.
REQ-029 Changes on req_* inputs while the block is not in IDLE SHALL have no effect.

Reset
REQ-030 Reset SHALL drive the FSM to IDLE, clear the counter, and clear resp_rdata, resp_fault and every MMIO register to 0.
REQ-031 While reset is asserted, req_ready SHALL be 0 and resp_valid SHALL be 0.
REQ-032 Reset mid-operation SHALL abort the request; a pending write not yet committed SHALL NOT occur.
REQ-033 Data and stack array contents SHALL NOT be reset.

Configuration
REQ-034 With macro MEM_CTRL_FAULT_EN defined, an unmapped access SHALL set resp_fault=1 and resp_rdata=0, and SHALL write nothing.
REQ-035 Without MEM_CTRL_FAULT_EN, resp_fault SHALL be tied to 0, unmapped reads SHALL return 0, and unmapped writes SHALL be dropped silently.

Structure
REQ-036 A shared package mem_ctrl_pkg SHALL hold the region encoding constants and the FSM state typedef.
REQ-037 A single sub-module mem_ctrl_ram SHALL implement a parametrised (DEPTH, DATA_W) synchronous-write word RAM, instantiated for the data and stack regions.
REQ-038 The MMIO register file SHALL be implemented inline in mem_ctrl.

Verification
REQ-039 Scenario 1: write 0xDEADBEEF to 0x0005, then read 0x0005 -> resp_rdata=0xDEADBEEF, resp_fault=0, each response exactly 2 cycles after accept (WAIT_CYCLES=1).
REQ-040 Scenario 2: write 0x11111111 to 0x4005, then read 0x0005 and 0x4005 -> data and stack words are distinct, and 0x4005 returns 0x11111111.
REQ-041 Scenario 3: write 0x000000A5 to 0x8003 -> mmio_q[127:96]=0x000000A5, all other MMIO registers remain 0.
REQ-042 Scenario 4: with FAULT_EN, read 0xC000 -> resp_fault=1, rdata=0; without FAULT_EN -> resp_fault=0, rdata=0.
REQ-043 Scenario 5: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata remain stable and req_ready=0 throughout; after one cycle with resp_ready=1 -> IDLE.
REQ-044 Scenario 6: assert reset during WAIT of a write to 0x0010 -> outputs return to reset values, and a later read of 0x0010 does not return the aborted data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: region encoding, FSM states
// and a width helper for power-of-two depths.
package mem_ctrl_pkg;

    localparam logic [1:0] REGION_DATA     = 2'b00;
    localparam logic [1:0] REGION_STACK    = 2'b01;
    localparam logic [1:0] REGION_MMIO     = 2'b10;
    localparam logic [1:0] REGION_UNMAPPED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index width for a power-of-two depth; never below 1 so ports stay legal.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_ram.sv
// Word RAM with synchronous write and combinational read; contents are not
// reset. Used for both the data and the stack region.
module mem_ctrl_ram
    import mem_ctrl_pkg::*;
#(
    parameter  int DEPTH  = 256,
    parameter  int DATA_W = 32,
    localparam int AW     = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Request/response memory controller decoding data, stack and MMIO regions.
// Optional macro MEM_CTRL_FAULT_EN reports unmapped accesses on resp_fault.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | wait states counting down from WAIT_CYCLES
// RESP  | response held until resp_ready
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DATA_DEPTH  = 256,
    parameter int STACK_DEPTH = 256,
    parameter int MMIO_REGS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_fault,
    output logic [MMIO_REGS*DATA_W-1:0] mmio_q
);

    localparam int         DATA_AW   = idx_w(DATA_DEPTH);
    localparam int         STACK_AW  = idx_w(STACK_DEPTH);
    localparam int         MMIO_AW   = idx_w(MMIO_REGS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_e                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic                        we_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [DATA_W-1:0]           rdata_q, rdata_d;
    logic                        fault_q, fault_d;
    logic [MMIO_REGS*DATA_W-1:0] mmio_flat_q;

    logic                        accept;
    logic                        exec;
    logic                        acc_we;
    logic [ADDR_W-1:0]           acc_addr;
    logic [DATA_W-1:0]           acc_wdata;
    logic [1:0]                  region;
    logic [MMIO_AW-1:0]          mmio_idx;
    logic [DATA_W-1:0]           data_rdata, stack_rdata, rd_mux;
    logic                        data_we, stack_we, mmio_we;
    logic                        unused_addr_bits;

    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign resp_valid = (state_q == ST_RESP);
    assign accept     = req_valid && req_ready;

    // With zero wait states the access executes on the accept edge itself,
    // so it must use the live request rather than the latched copy.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign exec = ((state_q == ST_IDLE) && accept && NO_WAIT) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd1));

    assign region           = acc_addr[ADDR_W-1 -: 2];
    assign mmio_idx         = acc_addr[MMIO_AW-1:0];
    assign unused_addr_bits = ^acc_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = NO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_we  = exec && acc_we && (region == REGION_DATA);
    assign stack_we = exec && acc_we && (region == REGION_STACK);
    assign mmio_we  = exec && acc_we && (region == REGION_MMIO);

    mem_ctrl_ram #(.DEPTH(DATA_DEPTH), .DATA_W(DATA_W)) u_data_ram (
        .clk   (clk),
        .we    (data_we),
        .addr  (acc_addr[DATA_AW-1:0]),
        .wdata (acc_wdata),
        .rdata (data_rdata)
    );

    mem_ctrl_ram #(.DEPTH(STACK_DEPTH), .DATA_W(DATA_W)) u_stack_ram (
        .clk   (clk),
        .we    (stack_we),
        .addr  (acc_addr[STACK_AW-1:0]),
        .wdata (acc_wdata),
        .rdata (stack_rdata)
    );

    always_comb begin
        rd_mux = '0;
        case (region)
            REGION_DATA:  rd_mux = data_rdata;
            REGION_STACK: rd_mux = stack_rdata;
            REGION_MMIO:  rd_mux = mmio_flat_q[int'(mmio_idx)*DATA_W +: DATA_W];
            default:      rd_mux = '0;
        endcase
    end

    assign rdata_d = acc_we ? '0 : rd_mux;

`ifdef MEM_CTRL_FAULT_EN
    assign fault_d = (region == REGION_UNMAPPED);
`else
    assign fault_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            mmio_flat_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Response fields only change on the edge entering RESP.
            if (exec) begin
                rdata_q <= rdata_d;
                fault_q <= fault_d;
            end
            if (mmio_we) begin
                mmio_flat_q[int'(mmio_idx)*DATA_W +: DATA_W] <= acc_wdata;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign mmio_q     = mmio_flat_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a reference memory model feeds an expected-
// response queue that is drained and checked as responses appear.
module tb_mem_ctrl;

    localparam int DW = 32;
    localparam int MR = 8;
`ifdef MEM_CTRL_FAULT_EN
    localparam bit FAULT_EXP = 1'b1;
`else
    localparam bit FAULT_EXP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_we;
    logic [15:0]    req_addr;
    logic [DW-1:0]  req_wdata;
    logic           resp_valid, resp_ready, resp_fault;
    logic [DW-1:0]  resp_rdata;
    logic [MR*DW-1:0] mmio_q;

    always #5 clk = ~clk;

    mem_ctrl #(
        .ADDR_W(16), .DATA_W(DW), .DATA_DEPTH(256), .STACK_DEPTH(256),
        .MMIO_REGS(MR), .WAIT_CYCLES(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mmio_q     (mmio_q)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          fault;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] data_m  [256];
    logic [DW-1:0] stack_m [256];
    logic [DW-1:0] mmio_m  [MR];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MR*DW-1:0] mmio_vec();
        logic [MR*DW-1:0] v;
        for (int i = 0; i < MR; i++) v[i*DW +: DW] = mmio_m[i];
        return v;
    endfunction

    // Reference behaviour of one access; updates the model on writes.
    function automatic exp_t model(input logic we, input logic [15:0] a, input logic [DW-1:0] wd);
        exp_t e;
        e.rdata = '0;
        e.fault = 1'b0;
        case (a[15:14])
            2'b00: if (we) data_m[a[7:0]] = wd;  else e.rdata = data_m[a[7:0]];
            2'b01: if (we) stack_m[a[7:0]] = wd; else e.rdata = stack_m[a[7:0]];
            2'b10: if (we) mmio_m[a[2:0]] = wd;  else e.rdata = mmio_m[a[2:0]];
            default: e.fault = FAULT_EXP;
        endcase
        return e;
    endfunction

    task automatic transact(input string tag, input logic we, input logic [15:0] addr,
                            input logic [DW-1:0] wdata, input int stall);
        exp_t          e;
        int            lat;
        logic [DW-1:0] held_rd;
        logic          held_f;
        chk({tag, "_ready"}, req_ready, 1'b1);
        sb.push_back(model(we, addr, wdata));
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble the request lines: they must be ignored once accepted.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 16'($urandom);
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 2);
        held_rd = resp_rdata;
        held_f  = resp_fault;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_flags"}, {resp_valid, req_ready}, 2'b10);
            chk({tag, "_stall_data"}, {held_f, held_rd}, {resp_fault, resp_rdata});
        end
        e = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_fault"}, resp_fault, e.fault);
        resp_ready = 1'b1;
        #1;
        chk({tag, "_no_accept_in_resp"}, req_ready, 1'b0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_back_idle"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < MR; i++) mmio_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_fault", resp_fault, 1'b0);
        chk("rst_mmio", mmio_q, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        transact("s1_wr",   1'b1, 16'h0005, 32'hDEADBEEF, 0);
        transact("s1_rd",   1'b0, 16'h0005, 32'h0, 0);

        transact("s2_wr",   1'b1, 16'h4005, 32'h11111111, 0);
        transact("s2_rd_d", 1'b0, 16'h0005, 32'h0, 0);
        transact("s2_rd_s", 1'b0, 16'h4005, 32'h0, 0);

        transact("s3_wr",   1'b1, 16'h8003, 32'h000000A5, 0);
        chk("s3_mmio", mmio_q, mmio_vec());
        transact("s3_rd",   1'b0, 16'h800B, 32'h0, 0);

        transact("wrap_wr", 1'b1, 16'h0105, 32'h55AA55AA, 0);
        transact("wrap_rd", 1'b0, 16'h0005, 32'h0, 0);

        transact("s4_rd",   1'b0, 16'hC000, 32'h0, 0);
        transact("s4_wr",   1'b1, 16'hC005, 32'h77777777, 0);
        transact("s4_rd_d", 1'b0, 16'h0005, 32'h0, 0);
        chk("s4_mmio", mmio_q, mmio_vec());

        transact("s5_rd",   1'b0, 16'h4005, 32'h0, 5);

        transact("s6_pre",  1'b1, 16'h0010, 32'h12345678, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        for (int i = 0; i < MR; i++) mmio_m[i] = '0;
        chk("s6_rst_flags", {req_ready, resp_valid}, 2'b00);
        chk("s6_rst_rdata", resp_rdata, 32'h0);
        chk("s6_rst_fault", resp_fault, 1'b0);
        chk("s6_rst_mmio", mmio_q, mmio_vec());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        transact("s6_rd",   1'b0, 16'h0010, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
